// File: rtl/sensor_pkg.sv
// Shared FSM state encodings and default timing constants for the car sensor filter.
package sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMING  = 3'd1,
        ST_PRESENT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam int DEF_DEB_TICKS   = 4;
    localparam int DEF_HOLD_TICKS  = 8;
    localparam int DEF_STUCK_TICKS = 200;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clear empties both stages.
module sync_2ff (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/car_sensor_filter.sv
// Debounce/hold filter for a country-road vehicle loop; drives registered request x.
// Optional stuck-sensor detection is enabled by defining SENSOR_STUCK_DET_EN.
module car_sensor_filter
    import sensor_pkg::*;
#(
    parameter int DEB_TICKS   = DEF_DEB_TICKS,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS,
    parameter int STUCK_TICKS = DEF_STUCK_TICKS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic clear,
    input  logic sensor_raw,
    input  logic tick,
    output logic x,
    output logic fault
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

    // Tick values outside 1..2^CNT_W-1 leave a terminal count unreachable.
    if (DEB_TICKS < 1 || DEB_TICKS >= (1 << CNT_W) ||
        HOLD_TICKS < 1 || HOLD_TICKS >= (1 << CNT_W) ||
        STUCK_TICKS < 1 || STUCK_TICKS >= (1 << CNT_W)) begin : g_unsupported_params
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic   s_sync;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic   x_q, x_d;
    logic   fault_q, fault_d;
`ifdef SENSOR_STUCK_DET_EN
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_TICKS - 1);
    logic [CNT_W-1:0] stuck_cnt_q, stuck_cnt_d;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .clear (clear),
        .d     (sensor_raw),
        .q     (s_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s_sync) begin
                    state_d = ST_ARMING;
                    cnt_d   = '0;
                end
            end
            ST_ARMING: begin
                if (!s_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_PRESENT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            ST_PRESENT: begin
                if (!s_sync) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (s_sync) begin
                    state_d = ST_PRESENT;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            ST_FAULT: begin
                // Recovery needs an unbroken run of quiet ticks.
                if (s_sync) begin
                    cnt_d = '0;
                end else if (tick) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef SENSOR_STUCK_DET_EN
        stuck_cnt_d = s_sync ? (tick ? sat_inc(stuck_cnt_q) : stuck_cnt_q) : '0;
        // Stuck detection outranks every other transition, from any state.
        if (s_sync && tick && stuck_cnt_q == STUCK_LAST) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
        end
        fault_d = (state_d == ST_FAULT);
`else
        fault_d = 1'b0;
`endif
        x_d = (state_d == ST_PRESENT) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            fault_q <= 1'b0;
`ifdef SENSOR_STUCK_DET_EN
            stuck_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            fault_q <= fault_d;
`ifdef SENSOR_STUCK_DET_EN
            stuck_cnt_q <= stuck_cnt_d;
`endif
        end
    end

    assign x     = x_q;
    assign fault = fault_q;

endmodule

// File: doc/car_sensor_filter.md
CAR_SENSOR_FILTER -- requirements
Module: car_sensor_filter

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 4: consecutive ticks of sensor presence needed to assert x.
REQ-002 SHALL have parameter HOLD_TICKS, default 8: ticks x stays high after the sensor drops.
REQ-003 SHALL have parameter STUCK_TICKS, default 200: continuous-presence ticks that declare the sensor stuck.
REQ-004 SHALL have parameter CNT_W, default 8: width of every tick counter.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on posedge clk.
REQ-006 SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port sensor_raw, input, 1 bit: asynchronous country-road loop detector, 1 = vehicle.
REQ-008 SHALL have port tick, input, 1 bit: single-cycle timebase enable.
REQ-009 SHALL have port x, output reg, 1 bit: qualified car-present request to the signal controller.
REQ-010 SHALL have port fault, output reg, 1 bit: sensor-stuck indication.

Function
REQ-011 SHALL synchronise sensor_raw through two flops to s_sync (2-clk latency); only s_sync is used afterwards.
REQ-012 SHALL advance counters only in cycles with tick=1; counter clear on state entry overrides tick in the same cycle.
REQ-013 SHALL implement FSM states IDLE, ARMING, PRESENT, HOLD, FAULT.
REQ-014 IDLE: x=0; s_sync=1 -> ARMING with cnt=0.
REQ-015 ARMING: x=0; s_sync=0 -> IDLE; tick with s_sync=1 increments cnt; tick when cnt==DEB_TICKS-1 -> PRESENT.
REQ-016 PRESENT: x=1; s_sync=0 -> HOLD with cnt=0.
REQ-017 HOLD: x=1; s_sync=1 -> PRESENT (hold aborted); tick increments cnt; tick when cnt==HOLD_TICKS-1 -> IDLE.
REQ-018 x SHALL be registered and change on the same edge the FSM enters or leaves {PRESENT, HOLD}; no combinational path from sensor_raw to x.
REQ-019 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 A sensor edge coinciding with the terminal tick SHALL be resolved by s_sync first: ARMING with s_sync=0 -> IDLE; HOLD with s_sync=1 -> PRESENT.
REQ-021 DEB_TICKS, HOLD_TICKS and STUCK_TICKS SHALL be >=1 and <2^CNT_W; other values are unsupported.

Reset
REQ-022 clear=1 SHALL force on the next edge: FSM=IDLE, all counters=0, sync flops=0, x=0, fault=0; clear overrides tick and sensor.
REQ-023 clear asserted mid-ARMING, PRESENT, HOLD or FAULT SHALL abandon the sequence; after release, qualification restarts from IDLE.

Configuration
REQ-024 With SENSOR_STUCK_DET_EN defined: stuck_cnt counts ticks while s_sync=1 in any state and clears when s_sync=0; tick at stuck_cnt==STUCK_TICKS-1 -> FAULT with fault=1, x=0.
REQ-025 FAULT SHALL exit to IDLE, clearing fault, after DEB_TICKS consecutive ticks with s_sync=0; any s_sync=1 restarts that count.
REQ-026 Without SENSOR_STUCK_DET_EN: no stuck_cnt, FAULT unreachable, fault tied to 0; the port list is unchanged.

Structure
REQ-027 Shared package sensor_pkg SHALL hold the FSM state encodings (3-bit) and the default DEB/HOLD/STUCK constants.
REQ-028 The two-flop synchroniser SHALL be sub-module sync_2ff (clk, clear, d, q).

Verification
REQ-029 Reset: clear=1 for 2 clk with sensor_raw=1 -> x=0, fault=0, state IDLE.
REQ-030 Qualify: sensor_raw=1 steady, tick every 4 clk -> x rises on the edge of the 4th tick after s_sync=1; a 3-tick pulse -> x stays 0.
REQ-031 Hold: car leaves -> x stays 1 for 8 ticks, falls on the 8th; sensor reasserts at tick 5 -> x never drops, FSM back in PRESENT.
REQ-032 Tie: s_sync falls on the same cycle as the 4th ARMING tick -> IDLE, x=0.
REQ-033 Stuck (macro on, STUCK_TICKS=10): sensor held 10 ticks -> fault=1, x=0; sensor low 4 ticks -> fault=0, IDLE; macro off -> fault stays 0, x stays 1.
REQ-034 Mid-operation clear in HOLD at tick 3 -> x=0 next edge; after release, a new car needs a full 4 ticks to assert x.
